// File: rtl/alu_hs_pipe.sv
// alu_hs_pipe: handshaked ALU. It captures one operation on an input
// handshake, runs it in a single EXEC cycle or through a W-step restoring
// divider, and then holds the gated result until the consumer accepts it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | empty, IN_READY=1, waiting for an operation
// S_EXEC | single-cycle op; result and flags load on the next edge
// S_DIV  | restoring divide, one quotient bit per cycle, then load result
// S_HOLD | OUT_VALID=1, result held until OUT_READY

module alu_hs_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int FUNC_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic [FUNC_WIDTH-1:0]     ALU_FUNC,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    output logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    output logic                      CARRY,
    output logic                      ZERO,
    output logic                      DIV0,
    output logic                      ERR,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
);

    localparam int W     = DATA_WIDTH;
    localparam int RW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);

    localparam logic [FUNC_WIDTH-1:0] F_ADD  = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] F_SUB  = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] F_MUL  = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] F_DIV  = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] F_AND  = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] F_OR   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] F_NAND = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] F_NOR  = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] F_XOR  = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] F_XNOR = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] F_EQ   = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] F_GT   = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] F_LT   = FUNC_WIDTH'(12);
    localparam logic [FUNC_WIDTH-1:0] F_SHR  = FUNC_WIDTH'(13);
    localparam logic [FUNC_WIDTH-1:0] F_SHL  = FUNC_WIDTH'(14);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [FUNC_WIDTH-1:0] r_func;
    logic [W-1:0]          r_quo;
    logic [W-1:0]          r_rem;
    logic [CNT_W-1:0]      r_cnt;
    logic [RW-1:0]         r_result;
    logic                  r_carry;
    logic                  r_div0;
    logic                  r_err;

    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_to_div;
    logic [RW-1:0]         w_a_ext;
    logic [RW-1:0]         w_b_ext;
    logic [RW-1:0]         w_sum;
    logic [RW-1:0]         w_res;
    logic                  w_carry;
    logic                  w_div0;
    logic                  w_err;
    logic [W:0]            w_rem_sh;
    logic [W:0]            w_rem_dif;
    logic                  w_ge;

    assign w_accept  = IN_VALID & IN_READY;
    // A divide by zero has a closed-form answer, so it skips the iterative path.
    assign w_to_div  = (ALU_FUNC == F_DIV) && (B != '0);
    assign w_a_ext   = {{W{1'b0}}, r_a};
    assign w_b_ext   = {{W{1'b0}}, r_b};
    assign w_sum     = w_a_ext + w_b_ext;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    assign w_rem_sh  = {r_rem, r_quo[W-1]};
    assign w_rem_dif = w_rem_sh - {1'b0, r_b};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (IN_VALID) begin
                    w_state_nxt = w_to_div ? S_DIV : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_HOLD;
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    if (IN_VALID) begin
                        w_state_nxt = w_to_div ? S_DIV : S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and gated result outputs.
    always_comb begin
        w_out_valid = (r_state == S_HOLD);
        OUT_VALID   = w_out_valid;
        IN_READY    = (r_state == S_IDLE) | (w_out_valid & OUT_READY);
        ALU_OUT     = w_out_valid ? r_result : '0;
        ZERO        = w_out_valid & (r_result == '0);
        CARRY       = w_out_valid & r_carry;
        DIV0        = w_out_valid & r_div0;
        ERR         = w_out_valid & r_err;
    end

    // Single-cycle operation results, evaluated from the captured operands.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_div0  = 1'b0;
        w_err   = 1'b0;
        case (r_func)
            F_ADD: begin
                w_res   = w_sum;
                w_carry = w_sum[W];
            end
            F_SUB: begin
                w_res   = w_a_ext - w_b_ext;
                w_carry = (r_a < r_b);
            end
            F_MUL:  w_res = w_a_ext * w_b_ext;
            // Only reachable with a zero divisor.
            F_DIV: begin
                w_res  = {r_a, {W{1'b1}}};
                w_div0 = 1'b1;
            end
            F_AND:  w_res = {{W{1'b0}}, r_a & r_b};
            F_OR:   w_res = {{W{1'b0}}, r_a | r_b};
            F_NAND: w_res = {{W{1'b0}}, ~(r_a & r_b)};
            F_NOR:  w_res = {{W{1'b0}}, ~(r_a | r_b)};
            F_XOR:  w_res = {{W{1'b0}}, r_a ^ r_b};
            F_XNOR: w_res = {{W{1'b0}}, ~(r_a ^ r_b)};
            F_EQ:   w_res = RW'(r_a == r_b);
            F_GT:   w_res = RW'(r_a > r_b);
            F_LT:   w_res = RW'(r_a < r_b);
            F_SHR:  w_res = w_a_ext >> r_b;
            F_SHL:  w_res = w_a_ext << r_b;
            default: w_err = 1'b1;
        endcase
    end

    // Operand capture, divider iteration and result/flag registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_a      <= '0;
            r_b      <= '0;
            r_func   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_div0   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_func <= ALU_FUNC;
            r_quo  <= A;
            r_rem  <= '0;
            r_cnt  <= CNT_LOAD;
        end else if (r_state == S_EXEC) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_div0   <= w_div0;
            r_err    <= w_err;
        end else if (r_state == S_DIV) begin
            if (r_cnt != '0) begin
                r_rem <= w_ge ? w_rem_dif[W-1:0] : w_rem_sh[W-1:0];
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_result <= {r_rem, r_quo};
                r_carry  <= 1'b0;
                r_div0   <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_hs_pipe.sv
// Bench for alu_hs_pipe: directed scenarios followed by randomized traffic
// with random output back-pressure; a queue-based scoreboard checks every
// accepted result against an arithmetic reference model.
`timescale 1ns/1ps

module tb_alu_hs_pipe;

    localparam int W  = 8;
    localparam int FW = 4;
    localparam int RW = 2 * W;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          carry;
        logic          zero;
        logic          div0;
        logic          err;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [FW-1:0] ALU_FUNC = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [RW-1:0] ALU_OUT;
    logic          CARRY;
    logic          ZERO;
    logic          DIV0;
    logic          ERR;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic bp_en = 1'b0;

    alu_hs_pipe #(.DATA_WIDTH(W), .FUNC_WIDTH(FW)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT),
        .CARRY(CARRY), .ZERO(ZERO), .DIV0(DIV0), .ERR(ERR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Arithmetic reference: results from the operation definitions on plain integers.
    function automatic exp_t ref_model(input int unsigned a, input int unsigned b, input int unsigned f);
        longint unsigned m  = 64'd1 << RW;
        longint unsigned hm = 64'd1 << W;
        longint unsigned r  = 0;
        exp_t e;
        e = '0;
        case (f)
            0: begin r = a + b; e.carry = ((a + b) >= hm); end
            1: begin r = (m + a - b) % m; e.carry = (a < b); end
            2: r = a * b;
            3: begin
                if (b == 0) begin
                    r = a * hm + (hm - 1);
                    e.div0 = 1'b1;
                end else begin
                    r = (a % b) * hm + (a / b);
                end
            end
            4: r = a & b;
            5: r = a | b;
            6: r = (hm - 1) ^ (a & b);
            7: r = (hm - 1) ^ (a | b);
            8: r = a ^ b;
            9: r = (hm - 1) ^ (a ^ b);
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 1 : 0;
            12: r = (a < b) ? 1 : 0;
            13: r = (b >= RW) ? 0 : (longint'(a) >> b);
            14: r = (b >= RW) ? 0 : ((longint'(a) << b) % m);
            default: e.err = 1'b1;
        endcase
        e.res  = RW'(r);
        e.zero = (r == 0);
        return e;
    endfunction

    // Present an operation, wait (bounded) for the handshake, record its
    // expected result, and return one step after the accepting edge.
    task automatic issue(input int unsigned a, input int unsigned b, input int unsigned f);
        int n = 0;
        A = W'(a);
        B = W'(b);
        ALU_FUNC = FW'(f);
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: IN_READY actual=0 required=1 within 100 cycles");
        end else begin
            sb.push_back(ref_model(a, b, f));
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        ALU_FUNC = FW'($urandom);
    endtask

    // Called one step after the accepting edge; lat = index of the edge after
    // which OUT_VALID is first seen, rdy_hi = cycles IN_READY was high before that.
    task automatic wait_out(output int lat, output int rdy_hi);
        lat = -1;
        rdy_hi = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                lat = k - 1;
                break;
            end
            if (IN_READY) rdy_hi++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Random back-pressure while enabled.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (bp_en) OUT_READY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: gating while invalid, stability under back-pressure, and
    // in-order comparison of every accepted output against the scoreboard.
    initial begin
        exp_t held;
        exp_t e;
        logic have_held;
        have_held = 1'b0;
        forever begin
            @(negedge CLK);
            if (!OUT_VALID) begin
                have_held = 1'b0;
                check("gated_outputs", {ALU_OUT, CARRY, ZERO, DIV0, ERR}, 0);
            end else begin
                if (have_held) check("hold_stable", {ALU_OUT, CARRY, ZERO, DIV0, ERR}, held);
                if (OUT_READY) begin
                    have_held = 1'b0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: actual ALU_OUT=0x%0h required no output", ALU_OUT);
                    end else begin
                        e = sb.pop_front();
                        check("sb_result", ALU_OUT, e.res);
                        check("sb_carry", CARRY, e.carry);
                        check("sb_zero", ZERO, e.zero);
                        check("sb_div0", DIV0, e.div0);
                        check("sb_err", ERR, e.err);
                    end
                end else begin
                    held = {ALU_OUT, CARRY, ZERO, DIV0, ERR};
                    have_held = 1'b1;
                end
            end
        end
    end

    initial begin
        int lat;
        int rh;
        int unstable;
        int rdy_hi;
        int n;
        logic [RW+3:0] snap;
        int unsigned ra, rb, rf;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_in_ready", IN_READY, 1);
        check("rst_alu_out", ALU_OUT, 0);
        check("rst_flags", {CARRY, ZERO, DIV0, ERR}, 0);
        RST = 1'b1;
        step();

        // ADD with carry out.
        issue(8'hFF, 8'h01, 0);
        wait_out(lat, rh);
        check("add_latency", lat, 1);
        check("add_out", ALU_OUT, 16'h0100);
        check("add_carry", CARRY, 1);
        check("add_zero", ZERO, 0);
        step();

        // SUB borrow, full-width MUL, shift left.
        issue(8'h05, 8'h07, 1);
        wait_out(lat, rh);
        check("sub_out", ALU_OUT, 16'hFFFE);
        check("sub_borrow", CARRY, 1);
        step();
        issue(8'hFF, 8'hFF, 2);
        wait_out(lat, rh);
        check("mul_out", ALU_OUT, 16'hFE01);
        step();
        issue(8'h81, 8'h04, 14);
        wait_out(lat, rh);
        check("shl_out", ALU_OUT, 16'h0810);
        step();

        // Iterative divide.
        issue(8'hC8, 8'h07, 3);
        wait_out(lat, rh);
        check("div_latency", lat, W + 1);
        check("div_in_ready_low", rh, 0);
        check("div_out", ALU_OUT, 16'h041C);
        check("div_div0", DIV0, 0);
        step();

        // Divide by zero and reserved code.
        issue(8'h37, 8'h00, 3);
        wait_out(lat, rh);
        check("div0_latency", lat, 1);
        check("div0_out", ALU_OUT, 16'h37FF);
        check("div0_flag", DIV0, 1);
        step();
        issue(8'h12, 8'h34, 15);
        wait_out(lat, rh);
        check("rsv_out", ALU_OUT, 0);
        check("rsv_err", ERR, 1);
        check("rsv_zero", ZERO, 1);
        step();

        // Back-pressure hold, then back-to-back accept.
        OUT_READY = 1'b0;
        issue(8'hA5, 8'hA5, 8);
        wait_out(lat, rh);
        snap = {ALU_OUT, CARRY, ZERO, DIV0, ERR};
        check("bp_zero", ZERO, 1);
        unstable = 0;
        rdy_hi = 0;
        repeat (5) begin
            @(negedge CLK);
            if ({ALU_OUT, CARRY, ZERO, DIV0, ERR} != snap || !OUT_VALID) unstable++;
            if (IN_READY) rdy_hi++;
        end
        check("bp_unstable_cycles", unstable, 0);
        check("bp_in_ready_high_cycles", rdy_hi, 0);
        step();
        OUT_READY = 1'b1;
        issue(8'hF0, 8'h3C, 4);
        wait_out(lat, rh);
        check("b2b_latency", lat, 1);
        check("b2b_out", ALU_OUT, 16'h0030);
        step();

        // Reset in the middle of a divide.
        issue(8'hC8, 8'h07, 3);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("midrst_out_valid", OUT_VALID, 0);
        check("midrst_alu_out", ALU_OUT, 0);
        check("midrst_in_ready", IN_READY, 1);
        sb.delete();
        step();
        step();
        RST = 1'b1;
        step();
        issue(8'h02, 8'h03, 0);
        wait_out(lat, rh);
        check("post_rst_latency", lat, 1);
        check("post_rst_out", ALU_OUT, 16'h0005);
        step();

        // Randomized traffic with back-pressure.
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rf = $urandom_range(0, 15);
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: rb = ra;
                2: ra = 255;
                3: rb = $urandom_range(0, 20);
                default: ;
            endcase
            issue(ra, rb, rf);
            repeat ($urandom_range(0, 2)) step();
        end
        bp_en = 1'b0;
        step();
        OUT_READY = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        repeat (5) step();
        check("drain_remaining", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
